bin2bcd_16: RTL and testbench

//  Sequential 16-bit binary to 5-digit packed-BCD converter (shift-add-3, "double dabble").

---
 rtl/bin2bcd_16_if.sv | 22 ++
 rtl/bin2bcd_16.sv | 87 ++++++++
 tb/tb_bin2bcd_16.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_16_if.sv
// bin2bcd_16_if: start/done handshake and data bus between the converter and its neighbours
//  init_in : start request level; its rising edge triggers one conversion
//  A       : 16-bit binary operand
//  BCD     : packed BCD result {d4,d3,d2,d1,d0}
//  done    : one-cycle pulse marking a new BCD result
//  busy    : high while a conversion is in flight
//  blank   : leading-zero digit mask (only when BCD_BLANK_EN is defined)
interface bin2bcd_16_if;
  logic        init_in;
  logic [15:0] A;
  logic [19:0] BCD;
  logic        done;
  logic        busy;
`ifdef BCD_BLANK_EN
  logic [4:0]  blank;
  modport master (output init_in, A, input BCD, done, busy, blank);
  modport slave  (input init_in, A, output BCD, done, busy, blank);
`else
  modport master (output init_in, A, input BCD, done, busy);
  modport slave  (input init_in, A, output BCD, done, busy);
`endif
endinterface

// File: rtl/bin2bcd_16.sv
// bin2bcd_16: sequential 16-bit binary to 5-digit packed BCD converter (double dabble)
//  clk, rst : rising-edge clock, synchronous active-high reset
//  bus      : bin2bcd_16_if slave (init_in, A in; BCD, done, busy out; blank out with BCD_BLANK_EN)
//  Optional leading-zero mask output enabled by defining BCD_BLANK_EN.
module bin2bcd_16 (
  input logic         clk,
  input logic         rst,
  bin2bcd_16_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t      r_state;
  logic        r_init_q;
  logic [3:0]  r_cnt;
  logic [15:0] r_bin;
  logic [19:0] r_bcd_sr;
  logic [19:0] r_bcd;
  logic        r_done;
  logic        r_busy;
  logic        w_start;
  logic [19:0] w_adj;
  logic [35:0] w_sh;
  assign w_start = bus.init_in & ~r_init_q;
  // Each digit is adjusted independently; a digit <= 9 becomes at most 12, so no carry crosses digits.
  for (genvar d = 0; d < 5; d++) begin : g_adj
    assign w_adj[4*d +: 4] = (r_bcd_sr[4*d +: 4] >= 4'd5) ? r_bcd_sr[4*d +: 4] + 4'd3 : r_bcd_sr[4*d +: 4];
  end
  assign w_sh = {w_adj, r_bin} << 1;
`ifdef BCD_BLANK_EN
  logic [4:0] r_blank;
  logic [4:0] w_blank;
  // Mask built from the final shifted value so it registers together with BCD.
  assign w_blank[4] = w_sh[35:32] == 4'd0;
  assign w_blank[3] = w_blank[4] & (w_sh[31:28] == 4'd0);
  assign w_blank[2] = w_blank[3] & (w_sh[27:24] == 4'd0);
  assign w_blank[1] = w_blank[2] & (w_sh[23:20] == 4'd0);
  assign w_blank[0] = 1'b0;
  assign bus.blank  = r_blank;
  always_ff @(posedge clk)
    if (rst) r_blank <= '0;
    else if (r_state == SHIFT && r_cnt == 4'd15) r_blank <= w_blank;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_init_q <= 1'b0;
      r_cnt    <= '0;
      r_bin    <= '0;
      r_bcd_sr <= '0;
      r_bcd    <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_init_q <= bus.init_in;
      r_done   <= 1'b0;
      case (r_state)
        IDLE: if (w_start) begin
          r_state <= LOAD;
          r_busy  <= 1'b1;
        end
        LOAD: begin
          r_bin    <= bus.A;
          r_bcd_sr <= '0;
          r_cnt    <= '0;
          r_state  <= SHIFT;
        end
        SHIFT: begin
          r_bcd_sr <= w_sh[35:16];
          r_bin    <= w_sh[15:0];
          r_cnt    <= r_cnt + 4'd1;
          // Result is registered on the last shift so it is visible during the DONE cycle.
          if (r_cnt == 4'd15) begin
            r_state <= DONE;
            r_bcd   <= w_sh[35:16];
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
  assign bus.BCD  = r_bcd;
  assign bus.done = r_done;
  assign bus.busy = r_busy;
endmodule

// File: tb/tb_bin2bcd_16.sv
// tb_bin2bcd_16: self-checking bench for bin2bcd_16 against a decimal-arithmetic reference
module tb_bin2bcd_16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  bin2bcd_16_if bus ();
  bin2bcd_16 dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_blank(input int v);
    logic [4:0] m = '0;
    int p = 10;
    for (int i = 1; i < 5; i++) begin
      m[i] = v < p;
      p = p * 10;
    end
    return m;
  endfunction

  task automatic convert(input logic [15:0] a, input int hold, output int lat, output int pulses,
                         output int busy_n, output logic [19:0] bcd);
    @(posedge clk); #1;
    bus.A = a; bus.init_in = 1'b1;
    lat = -1; pulses = 0; busy_n = 0; bcd = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == hold) bus.init_in = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        pulses++;
        if (lat < 0) begin lat = k; bcd = bus.BCD; end
      end
    end
    bus.init_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.init_in = 1'b0; bus.A = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.BCD !== 20'h0) begin errors++; $display("FAIL reset_bcd got %h exp 00000", bus.BCD); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
`ifdef BCD_BLANK_EN
    checks++; if (bus.blank !== 5'b0) begin errors++; $display("FAIL reset_blank got %b exp 00000", bus.blank); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_vectors;
    logic [15:0] vals [3] = '{16'h00BE, 16'hFFFF, 16'h0000};
    int lat, pulses, busy_n;
    logic [19:0] bcd;
    foreach (vals[i]) begin
      convert(vals[i], 2, lat, pulses, busy_n, bcd);
      checks++; if (bcd !== ref_bcd(int'(vals[i]))) begin errors++; $display("FAIL vec_bcd A=%h got %h exp %h", vals[i], bcd, ref_bcd(int'(vals[i]))); end
      checks++; if (lat !== 18) begin errors++; $display("FAIL vec_latency A=%h got %0d exp 18", vals[i], lat); end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL vec_pulses A=%h got %0d exp 1", vals[i], pulses); end
      checks++; if (busy_n !== 18) begin errors++; $display("FAIL vec_busy_cycles A=%h got %0d exp 18", vals[i], busy_n); end
`ifdef BCD_BLANK_EN
      checks++; if (bus.blank !== ref_blank(int'(vals[i]))) begin errors++; $display("FAIL vec_blank A=%h got %b exp %b", vals[i], bus.blank, ref_blank(int'(vals[i]))); end
`endif
    end
  endtask

  task automatic test_hold;
    int lat, pulses, busy_n;
    logic [19:0] bcd;
    convert(16'd1234, 40, lat, pulses, busy_n, bcd);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL hold_pulses got %0d exp 1", pulses); end
    checks++; if (bcd !== 20'h01234) begin errors++; $display("FAIL hold_bcd got %h exp 01234", bcd); end
  endtask

  task automatic test_ignore_busy;
    int lat = -1, pulses = 0;
    logic [19:0] bcd = 'x;
    @(posedge clk); #1;
    bus.A = 16'd4321; bus.init_in = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus.init_in = 1'b0;
      if (k == 6) begin bus.A = 16'd9; bus.init_in = 1'b1; end
      if (k == 7) bus.init_in = 1'b0;
      if (bus.done) begin
        pulses++;
        if (lat < 0) begin lat = k; bcd = bus.BCD; end
      end
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL ignore_pulses got %0d exp 1", pulses); end
    checks++; if (bcd !== ref_bcd(4321)) begin errors++; $display("FAIL ignore_bcd got %h exp %h", bcd, ref_bcd(4321)); end
    checks++; if (bus.BCD !== ref_bcd(4321)) begin errors++; $display("FAIL ignore_hold got %h exp %h", bus.BCD, ref_bcd(4321)); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_idle_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_reset_mid;
    int lat, pulses = 0, busy_n;
    logic [19:0] bcd;
    @(posedge clk); #1;
    bus.A = 16'd777; bus.init_in = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus.init_in = 1'b0;
      if (bus.done) pulses++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (bus.BCD !== 20'h0) begin errors++; $display("FAIL midrst_bcd got %h exp 00000", bus.BCD); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", bus.busy); end
    for (int k = 0; k < 25; k++) begin
      if (bus.done) pulses++;
      @(posedge clk); #1;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", pulses); end
    convert(16'd10000, 1, lat, pulses, busy_n, bcd);
    checks++; if (bcd !== 20'h10000) begin errors++; $display("FAIL midrst_restart got %h exp 10000", bcd); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] a1, a2;
    int n = 0, lat1 = -1, lat2 = -1;
    logic [19:0] b1 = 'x, b2 = 'x;
    a1 = 16'($urandom_range(0, 65535));
    a2 = 16'($urandom_range(0, 65535));
    @(posedge clk); #1;
    bus.A = a1; bus.init_in = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus.init_in = 1'b0;
      if (k == 19) begin bus.A = a2; bus.init_in = 1'b1; end
      if (k == 20) bus.init_in = 1'b0;
      if (bus.done) begin
        n++;
        if (n == 1) begin lat1 = k; b1 = bus.BCD; end
        if (n == 2) begin lat2 = k; b2 = bus.BCD; end
      end
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", n); end
    checks++; if (lat1 !== 18 || lat2 !== 37) begin errors++; $display("FAIL b2b_latency got %0d,%0d exp 18,37", lat1, lat2); end
    checks++; if (b1 !== ref_bcd(int'(a1))) begin errors++; $display("FAIL b2b_first got %h exp %h", b1, ref_bcd(int'(a1))); end
    checks++; if (b2 !== ref_bcd(int'(a2))) begin errors++; $display("FAIL b2b_second got %h exp %h", b2, ref_bcd(int'(a2))); end
  endtask

  task automatic test_chain;
    int q = 50000 / 7;
    int lat, pulses, busy_n;
    logic [19:0] bcd;
    convert(16'(q), 30, lat, pulses, busy_n, bcd);
    checks++; if (bcd !== 20'h07142) begin errors++; $display("FAIL chain_bcd got %h exp 07142", bcd); end
  endtask

  task automatic test_random;
    int lat, pulses, busy_n;
    logic [19:0] bcd;
    logic [15:0] a;
    for (int i = 0; i < 12; i++) begin
      a = 16'($urandom_range(0, 65535));
      convert(a, int'($urandom_range(1, 3)), lat, pulses, busy_n, bcd);
      checks++; if (bcd !== ref_bcd(int'(a)) || lat !== 18) begin errors++; $display("FAIL rand A=%0d got %h lat %0d exp %h lat 18", a, bcd, lat, ref_bcd(int'(a))); end
`ifdef BCD_BLANK_EN
      checks++; if (bus.blank !== ref_blank(int'(a))) begin errors++; $display("FAIL rand_blank A=%0d got %b exp %b", a, bus.blank, ref_blank(int'(a))); end
`endif
    end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_hold;
    test_ignore_busy;
    test_reset_mid;
    test_back_to_back;
    test_chain;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
